// File: rtl/pipe_rc_adder.sv
// ---------------------------------------------------------------------------
// pipe_rc_adder
//   Pipelined ripple-carry adder/subtractor. The WIDTH-bit operation is cut
//   into STAGES chunks of CHUNK bits. Each stage ripples one chunk and
//   registers its carry-out, which feeds the next chunk one cycle later.
//   Operands travel down the pipe alongside the partial sum so every
//   operation stays coherent. A valid/ready handshake with a global stall
//   provides backpressure.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth; WIDTH must be a multiple of STAGES
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand set presented
//   in_ready   block accepts operands this cycle
//   a, b       operands
//   cin        carry-in (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result presented
//   out_ready  consumer accepts the result
//   sum        result
//   cout       carry-out; not-borrow when subtracting
//   ovf        two's-complement signed overflow
// ---------------------------------------------------------------------------
module pipe_rc_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    // Per-stage registers. Index k holds the state produced by stage k.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];   // effective B (already inverted for subtract)
    logic [WIDTH-1:0]  s_q [STAGES];   // chunks 0..k summed, upper bits zero
    logic [STAGES-1:0] c_q;            // carry out of chunk k
    logic [STAGES-1:0] v_q;
    logic              ovf_q;

    // Stage inputs (also the next-state for the operand registers).
    logic [WIDTH-1:0]  a_d  [STAGES];
    logic [WIDTH-1:0]  b_d  [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] v_d;

    // Stage outputs.
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_d;
    logic              ovf_d;

    logic              stall;

    // Stall only depends on registered state and out_ready; never on in_valid.
    assign stall    = v_q[STAGES-1] & ~out_ready;
    assign in_ready = ~rst & ~stall;

    // Route each stage's inputs: stage 0 takes the ports, later stages take
    // the previous stage's registers.
    always_comb begin : stage_inputs
        a_d[0]  = a;
        b_d[0]  = b ^ {WIDTH{sub}};
        s_in[0] = '0;
        c_in[0] = sub | cin;
        // While not stalled in_ready is 1, so a transfer in equals in_valid.
        v_d[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_d[k]  = v_q[k-1];
        end
    end

    // Ripple one chunk per stage.
    always_comb begin : ripple
        logic carry;
        logic carry_msb;
        ovf_d = 1'b0;
        c_d   = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k]    = s_in[k];
            carry     = c_in[k];
            carry_msb = c_in[k];
            for (int i = 0; i < CHUNK; i++) begin
                s_d[k][k*CHUNK+i] = a_d[k][k*CHUNK+i] ^ b_d[k][k*CHUNK+i] ^ carry;
                // After the last iteration this is the carry into the chunk MSB.
                carry_msb = carry;
                carry = (a_d[k][k*CHUNK+i] & b_d[k][k*CHUNK+i]) |
                        (carry & (a_d[k][k*CHUNK+i] ^ b_d[k][k*CHUNK+i]));
            end
            c_d[k] = carry;
            if (k == STAGES - 1) begin
                ovf_d = carry_msb ^ carry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_rc_adder.sv
// Scoreboard bench for pipe_rc_adder (WIDTH=16, STAGES=4).
module tb_pipe_rc_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipe_rc_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    bit   chk_lat = 1'b1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        exp_t          e;
        longint        sx;
        longint        sy;
        longint        r;
        longint unsigned ux;
        longint unsigned uy;
        longint unsigned u;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        if (s) begin
            u      = ux - uy;
            e.sum  = u[W-1:0];
            e.cout = (ux >= uy);
            r      = sx - sy;
        end else begin
            u      = ux + uy + ci;
            e.sum  = u[W-1:0];
            e.cout = u[W];
            r      = sx + sy + ci;
        end
        e.ovf = (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: pop and compare on every transfer out.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got sum=%0h with no pending op", sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sum", sum, mon_e.sum);
                chk("cout", cout, mon_e.cout);
                chk("ovf", ovf, mon_e.ovf);
                if (chk_lat) chk("latency", cyc - mon_e.acc, S);
                n_out++;
            end
        end
    end

    // Called at posedge+1; returns at the posedge+1 after the op is accepted.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s);
        exp_t e;
        int   waitc;
        waitc = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        sub = s;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1'b1);
        end else begin
            e = model(x, y, ci, s);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 500) begin
            waitc++;
            @(negedge clk);
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    bit rnd_done;
    int n0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed single ops (latency checked by monitor)
        send(16'h0001, 16'h0004, 1'b0, 1'b0);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0003, 16'h0005, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();

        // Back-to-back stream
        send(16'h0010, 16'h0040, 1'b0, 1'b0);
        send(16'h00D0, 16'h0020, 1'b0, 1'b0);
        send(16'h07C6, 16'h003A, 1'b0, 1'b0);
        send(16'h5FFF, 16'h6D3F, 1'b0, 1'b0);
        drain();

        // Backpressure with a full pipe
        chk_lat = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
            end
            begin
                int waitc;
                waitc = 0;
                @(negedge clk);
                while (!out_valid && waitc < 50) begin
                    waitc++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 1'b0);
                    chk("stall_out_valid", out_valid, 1'b1);
                    if (exp_q.size() != 0) chk("stall_sum_hold", sum, exp_q[0].sum);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", n_out - n0, 8);

        // Randomized traffic with random backpressure and bubbles
        rnd_done = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("rnd_count", n_out - n0, 200);
        chk_lat = 1'b1;

        // Reset with operations in flight
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h00FF, 16'h0F00, 1'b0, 1'b0);
        begin
            int waitc;
            waitc = 0;
            @(negedge clk);
            while (!out_valid && waitc < 50) begin
                waitc++;
                @(negedge clk);
            end
            chk("pre_rst_out_valid", out_valid, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_sum", sum, 16'h0000);
        chk("async_rst_in_ready", in_ready, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_output", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send(16'h0002, 16'h0003, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_rc_adder.md
Name: pipe_rc_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the team's fixed 16-bit combinational ripple adder.
- The WIDTH-bit operation is split into STAGES equal chunks. Each chunk's ripple carry is registered before it enters the next chunk, so a new operation can be accepted every cycle at higher clock rates.
- Adds a subtract mode, signed-overflow detection and a valid/ready handshake with backpressure.
- Sits between operand-producing logic and any result consumer in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages; WIDTH % STAGES == 0 required. CHUNK = WIDTH/STAGES bits are rippled per stage.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; for subtract it is the not-borrow flag (1 iff a ≥ b unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (asynchronous, rst=1):
  - All pipeline registers, per-stage valid bits, sum, cout, ovf and out_valid are cleared to 0.
  - in_ready is 1 while rst is 0 and the pipeline is not stalled. During reset in_ready is 0.
  - Any operations in flight are discarded. No output is produced for them after reset is released.
- Operand preparation at stage 0:
  - Effective B is b XOR {WIDTH{sub}}.
  - Effective carry-in is sub ? 1 : cin.
- Stage k (k = 0..STAGES-1):
  - Computes chunk k, bits [k·CHUNK +: CHUNK], from the effective operands and the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - Registers the chunk sum and the chunk carry-out.
  - Passes the not-yet-summed upper operand chunks and the already-summed lower chunks forward. The skew registers keep each operation coherent.
- Final stage:
  - sum is the concatenated chunk sums.
  - cout is the final chunk carry.
  - ovf = carry into the MSB XOR carry out of the MSB. This equals (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), using the effective B.
- Result is exact modulo 2^WIDTH and identical to a full-width combinational add.
- Handshake:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready. While stalled, every stage register holds and in_ready=0.
  - When not stalled, all stages advance together and in_ready=1. in_ready depends only on registered state and out_ready; it has no path from in_valid.
  - A bubble (in_valid=0 at an advance) propagates as a stage with valid=0.
- Timing:
  - Latency is STAGES cycles from the accepting edge to out_valid=1, with no stall.
  - Throughput is 1 operation per cycle with out_ready held at 1.
  - Results emerge strictly in acceptance order.
- While out_valid=1 and out_ready=0, sum, cout and ovf stay stable.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.
- STAGES=1 degenerates to a single registered full-width ripple with latency 1.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0x0001, b=0x0004, cin=0, sub=0 → 4 cycles later sum=0x0005, cout=0, ovf=0.
- Full-length carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0003, b=0x0005, sub=1, cin=1 (cin is ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Back-to-back stream 0x0010+0x0040, 0x00D0+0x0020, 0x07C6+0x003A, 0x5FFF+0x6D3F on consecutive cycles → results 0x0050, 0x00F0, 0x0800, 0xCD3E (ovf=1) on 4 consecutive cycles starting cycle 4.
- Backpressure: drop out_ready for 3 cycles while the pipe is full → in_ready=0 and outputs hold those 3 cycles. Raise out_ready → all results delivered in order, none lost or duplicated.
- Reset mid-stream: assert rst with 2 operations in flight → out_valid=0 and sum=0 immediately (asynchronous). After release, no stale results appear; a new op 0x0002+0x0003 yields 0x0005 after 4 cycles.
